// File: rtl/ctl_round.sv
// Round/game controller for N players: releases ducks, tracks per-player BCD ammo and score,
// decides hit or escape for each duck, and pass/fail plus game over at the end of each round.
module ctl_round #(
    parameter int N_PLAYERS       = 2,
    parameter int AMMO_PER_DUCK   = 3,
    parameter int DUCKS_PER_ROUND = 10,
    parameter int PASS_HITS       = 6,
    parameter int FLY_FRAMES      = 300,
    parameter int RESULT_FRAMES   = 60
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     new_frame,
    input  logic                     start,
    input  logic                     pause,
    input  logic [N_PLAYERS-1:0]     shot,
    input  logic [N_PLAYERS-1:0]     hit,
    output logic                     duck_release,
    output logic                     duck_hit,
    output logic                     duck_escape,
    output logic [8*N_PLAYERS-1:0]   score_bcd,
    output logic [4*N_PLAYERS-1:0]   ammo_bcd,
    output logic [7:0]               round_bcd,
    output logic [3:0]               duck_idx,
    output logic                     game_over
);
    localparam logic [3:0] AMMO_FULL  = 4'(AMMO_PER_DUCK);
    localparam logic [3:0] DUCKS_LAST = 4'(DUCKS_PER_ROUND - 1);
    localparam logic [3:0] PASS_MIN   = 4'(PASS_HITS);
    localparam logic [9:0] FLY_LAST   = 10'(FLY_FRAMES - 1);
    localparam logic [9:0] RES_LAST   = 10'(RESULT_FRAMES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RELEASE,
        S_FLY,
        S_FALL,
        S_ESCAPE,
        S_ROUND_END,
        S_GAME_OVER
    } state_t;

    state_t                    state_q, state_d;
    logic [N_PLAYERS-1:0][7:0] score_q, score_d;
    logic [N_PLAYERS-1:0][3:0] ammo_q, ammo_d;
    logic [7:0]                round_q, round_d;
    logic [3:0]                duck_q, duck_d;
    logic [3:0]                hits_q, hits_d;
    logic [9:0]                fly_q, fly_d;
    logic [9:0]                res_q, res_d;
    logic                      release_q, release_d;
    logic                      fall_q, fall_d;
    logic                      escape_q, escape_d;
    logic                      over_q, over_d;
    logic                      enter_release;
    logic                      hit_found;

    function automatic logic [7:0] bcd_inc_sat(input logic [7:0] v);
        if (v == 8'h99)
            return v;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // Every transition into RELEASE shares the reload/pulse actions, so they are applied once at the end.
    always_comb begin
        state_d       = state_q;
        score_d       = score_q;
        ammo_d        = ammo_q;
        round_d       = round_q;
        duck_d        = duck_q;
        hits_d        = hits_q;
        fly_d         = fly_q;
        res_d         = res_q;
        release_d     = 1'b0;
        enter_release = 1'b0;
        hit_found     = 1'b0;

        if (!pause) begin
            case (state_q)
                S_IDLE, S_GAME_OVER: begin
                    if (start) begin
                        score_d       = '0;
                        duck_d        = '0;
                        round_d       = 8'h01;
                        hits_d        = '0;
                        enter_release = 1'b1;
                    end
                end
                S_RELEASE: state_d = S_FLY;
                S_FLY: begin
                    for (int i = 0; i < N_PLAYERS; i++) begin
                        if (shot[i] && ammo_q[i] != 4'd0) begin
                            ammo_d[i] = ammo_q[i] - 4'd1;
                            if (hit[i] && !hit_found) begin
                                hit_found  = 1'b1;
                                score_d[i] = bcd_inc_sat(score_q[i]);
                            end
                        end
                    end
                    if (new_frame)
                        fly_d = fly_q + 10'd1;
                    if (hit_found) begin
                        state_d = S_FALL;
                        hits_d  = hits_q + 4'd1;
                        res_d   = '0;
                    end else if ((new_frame && fly_q == FLY_LAST) || ammo_d == '0) begin
                        state_d = S_ESCAPE;
                        res_d   = '0;
                    end
                end
                S_FALL, S_ESCAPE: begin
                    if (new_frame) begin
                        res_d = res_q + 10'd1;
                        if (res_q == RES_LAST) begin
                            duck_d = duck_q + 4'd1;
                            if (duck_q == DUCKS_LAST)
                                state_d = S_ROUND_END;
                            else
                                enter_release = 1'b1;
                        end
                    end
                end
                S_ROUND_END: begin
                    if (hits_q >= PASS_MIN) begin
                        round_d       = bcd_inc_sat(round_q);
                        duck_d        = '0;
                        hits_d        = '0;
                        enter_release = 1'b1;
                    end else begin
                        state_d = S_GAME_OVER;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        if (enter_release) begin
            state_d   = S_RELEASE;
            release_d = 1'b1;
            fly_d     = '0;
            for (int i = 0; i < N_PLAYERS; i++)
                ammo_d[i] = AMMO_FULL;
        end

        fall_d   = (state_d == S_FALL);
        escape_d = (state_d == S_ESCAPE);
        over_d   = (state_d == S_GAME_OVER);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            score_q   <= '0;
            ammo_q    <= '0;
            round_q   <= 8'h01;
            duck_q    <= '0;
            hits_q    <= '0;
            fly_q     <= '0;
            res_q     <= '0;
            release_q <= 1'b0;
            fall_q    <= 1'b0;
            escape_q  <= 1'b0;
            over_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            score_q   <= score_d;
            ammo_q    <= ammo_d;
            round_q   <= round_d;
            duck_q    <= duck_d;
            hits_q    <= hits_d;
            fly_q     <= fly_d;
            res_q     <= res_d;
            release_q <= release_d;
            fall_q    <= fall_d;
            escape_q  <= escape_d;
            over_q    <= over_d;
        end
    end

    assign duck_release = release_q;
    assign duck_hit     = fall_q;
    assign duck_escape  = escape_q;
    assign game_over    = over_q;
    assign score_bcd    = score_q;
    assign ammo_bcd     = ammo_q;
    assign round_bcd    = round_q;
    assign duck_idx     = duck_q;
endmodule

// File: tb/tb_ctl_round.sv
// Bench for ctl_round: vector table, directed multi-cycle sequences and random stimulus,
// all checked cycle by cycle against a behavioural model that uses plain integer arithmetic.
module tb_ctl_round;
    localparam int N     = 2;
    localparam int AMMO  = 3;
    localparam int DUCKS = 10;
    localparam int PASS  = 6;
    localparam int FLY   = 300;
    localparam int RES   = 60;

    localparam int P_IDLE = 0, P_REL = 1, P_FLY = 2, P_FALL = 3, P_ESC = 4, P_RE = 5, P_GO = 6;

    logic           clk = 1'b0;
    logic           rst;
    logic           new_frame, start, pause;
    logic [N-1:0]   shot, hit;
    logic           duck_release, duck_hit, duck_escape, game_over;
    logic [8*N-1:0] score_bcd;
    logic [4*N-1:0] ammo_bcd;
    logic [7:0]     round_bcd;
    logic [3:0]     duck_idx;

    int checks = 0;
    int passes = 0;

    int m_phase, m_round, m_duck, m_hits, m_fly, m_res;
    int m_score[N];
    int m_ammo[N];
    bit m_rel;

    typedef struct {
        logic [N-1:0]   shot;
        logic [N-1:0]   hit;
        logic           nf;
        logic           st;
        logic           ps;
        logic [8*N-1:0] score;
        logic [4*N-1:0] ammo;
        logic [3:0]     flags;
        logic [3:0]     duck;
    } vec_t;

    vec_t table_v[5];

    ctl_round #(
        .N_PLAYERS(N), .AMMO_PER_DUCK(AMMO), .DUCKS_PER_ROUND(DUCKS),
        .PASS_HITS(PASS), .FLY_FRAMES(FLY), .RESULT_FRAMES(RES)
    ) dut (
        .clk(clk), .rst(rst), .new_frame(new_frame), .start(start), .pause(pause),
        .shot(shot), .hit(hit), .duck_release(duck_release), .duck_hit(duck_hit),
        .duck_escape(duck_escape), .score_bcd(score_bcd), .ammo_bcd(ammo_bcd),
        .round_bcd(round_bcd), .duck_idx(duck_idx), .game_over(game_over)
    );

    always #5 clk = ~clk;

    initial begin
        #10000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [7:0] toBcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    task automatic checkValue(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual === expected)
            passes++;
        else
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    endtask

    task automatic modelReset();
        m_phase = P_IDLE;
        m_round = 1;
        m_duck  = 0;
        m_hits  = 0;
        m_fly   = 0;
        m_res   = 0;
        m_rel   = 1'b0;
        for (int i = 0; i < N; i++) begin
            m_score[i] = 0;
            m_ammo[i]  = 0;
        end
    endtask

    task automatic modelRelease();
        m_phase = P_REL;
        m_rel   = 1'b1;
        m_fly   = 0;
        for (int i = 0; i < N; i++)
            m_ammo[i] = AMMO;
    endtask

    task automatic modelStep(input logic [N-1:0] s_in, input logic [N-1:0] h_in,
                             input logic nf, input logic st, input logic ps);
        int winner;
        int left;
        m_rel = 1'b0;
        if (!ps) begin
            case (m_phase)
                P_IDLE, P_GO: begin
                    if (st) begin
                        for (int i = 0; i < N; i++)
                            m_score[i] = 0;
                        m_duck  = 0;
                        m_round = 1;
                        m_hits  = 0;
                        modelRelease();
                    end
                end
                P_REL: m_phase = P_FLY;
                P_FLY: begin
                    winner = -1;
                    for (int i = 0; i < N; i++) begin
                        if (s_in[i] && m_ammo[i] > 0) begin
                            m_ammo[i]--;
                            if (h_in[i] && winner < 0)
                                winner = i;
                        end
                    end
                    if (nf)
                        m_fly++;
                    left = 0;
                    for (int i = 0; i < N; i++)
                        left += m_ammo[i];
                    if (winner >= 0) begin
                        m_score[winner] = (m_score[winner] < 99) ? m_score[winner] + 1 : 99;
                        m_hits++;
                        m_res   = 0;
                        m_phase = P_FALL;
                    end else if ((nf && m_fly >= FLY) || left == 0) begin
                        m_res   = 0;
                        m_phase = P_ESC;
                    end
                end
                P_FALL, P_ESC: begin
                    if (nf) begin
                        m_res++;
                        if (m_res == RES) begin
                            m_duck++;
                            if (m_duck == DUCKS)
                                m_phase = P_RE;
                            else
                                modelRelease();
                        end
                    end
                end
                P_RE: begin
                    if (m_hits >= PASS) begin
                        m_round = (m_round < 99) ? m_round + 1 : 99;
                        m_duck  = 0;
                        m_hits  = 0;
                        modelRelease();
                    end else begin
                        m_phase = P_GO;
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic checkOutput(input string tag);
        logic [8*N-1:0] es;
        logic [4*N-1:0] ea;
        logic [3:0]     ef;
        for (int i = 0; i < N; i++) begin
            es[8*i +: 8] = toBcd(m_score[i]);
            ea[4*i +: 4] = 4'(m_ammo[i]);
        end
        ef = {m_rel, m_phase == P_FALL, m_phase == P_ESC, m_phase == P_GO};
        checkValue({tag, " score"}, 64'(score_bcd), 64'(es));
        checkValue({tag, " ammo"}, 64'(ammo_bcd), 64'(ea));
        checkValue({tag, " round"}, 64'(round_bcd), 64'(toBcd(m_round)));
        checkValue({tag, " duck_idx"}, 64'(duck_idx), 64'(m_duck));
        checkValue({tag, " flags"}, 64'({duck_release, duck_hit, duck_escape, game_over}), 64'(ef));
    endtask

    task automatic checkExpect(input string tag, input logic [8*N-1:0] es, input logic [4*N-1:0] ea,
                               input logic [3:0] ef, input logic [3:0] ed);
        checkValue({tag, " score"}, 64'(score_bcd), 64'(es));
        checkValue({tag, " ammo"}, 64'(ammo_bcd), 64'(ea));
        checkValue({tag, " flags"}, 64'({duck_release, duck_hit, duck_escape, game_over}), 64'(ef));
        checkValue({tag, " duck_idx"}, 64'(duck_idx), 64'(ed));
    endtask

    task automatic applyStimulus(input logic [N-1:0] s_in, input logic [N-1:0] h_in,
                                 input logic nf, input logic st, input logic ps, input string tag);
        shot      = s_in;
        hit       = h_in;
        new_frame = nf;
        start     = st;
        pause     = ps;
        @(posedge clk);
        modelStep(s_in, h_in, nf, st, ps);
        #1;
        checkOutput(tag);
        @(negedge clk);
    endtask

    task automatic frames(input int n, input logic ps);
        for (int k = 0; k < n; k++) begin
            applyStimulus('0, '0, 1'b1, 1'b0, ps, "frame");
            applyStimulus('0, '0, 1'b0, 1'b0, ps, "frame");
        end
    endtask

    task automatic waitFly();
        int guard;
        guard = 0;
        while (m_phase != P_FLY && guard < 8) begin
            applyStimulus('0, '0, 1'b0, 1'b0, 1'b0, "wait");
            guard++;
        end
        if (m_phase != P_FLY) begin
            checks++;
            $display("[TB] FAIL wait_fly: got phase %0d, expected FLY within 8 cycles", m_phase);
        end
    endtask

    task automatic hitDuck(input int p);
        logic [N-1:0] sel;
        sel = '0;
        sel[p] = 1'b1;
        waitFly();
        applyStimulus(sel, sel, 1'b0, 1'b0, 1'b0, "hit duck");
        frames(RES, 1'b0);
    endtask

    task automatic escapeDuck();
        waitFly();
        for (int k = 0; k < AMMO; k++)
            applyStimulus('1, '0, 1'b0, 1'b0, 1'b0, "miss");
        frames(RES, 1'b0);
    endtask

    task automatic checkReset(input string tag);
        checkExpect(tag, '0, '0, 4'b0000, 4'd0);
        checkValue({tag, " round"}, 64'(round_bcd), 64'h01);
    endtask

    initial begin
        table_v[0] = '{2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 16'h0000, 8'h33, 4'b1000, 4'd0};
        table_v[1] = '{2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h33, 4'b0000, 4'd0};
        table_v[2] = '{2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 16'h0001, 8'h32, 4'b0100, 4'd0};
        table_v[3] = '{2'b10, 2'b10, 1'b1, 1'b0, 1'b0, 16'h0001, 8'h32, 4'b0100, 4'd0};
        table_v[4] = '{2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 16'h0001, 8'h32, 4'b0100, 4'd0};

        rst = 1'b0;
        shot = '0;
        hit = '0;
        new_frame = 1'b0;
        start = 1'b0;
        pause = 1'b0;
        modelReset();
        repeat (2) @(negedge clk);
        checkReset("reset");
        rst = 1'b1;

        for (int v = 0; v < 5; v++) begin
            applyStimulus(table_v[v].shot, table_v[v].hit, table_v[v].nf, table_v[v].st, table_v[v].ps, "vec");
            checkExpect($sformatf("vec%0d", v), table_v[v].score, table_v[v].ammo, table_v[v].flags, table_v[v].duck);
        end

        frames(RES - 1, 1'b0);
        checkExpect("second duck", 16'h0001, 8'h33, 4'b0000, 4'd1);

        applyStimulus(2'b11, 2'b11, 1'b0, 1'b0, 1'b0, "double hit");
        checkExpect("double hit", 16'h0002, 8'h22, 4'b0100, 4'd1);
        frames(RES, 1'b0);

        applyStimulus(2'b00, 2'b11, 1'b0, 1'b0, 1'b0, "hit no shot");
        checkExpect("hit no shot", 16'h0002, 8'h33, 4'b0000, 4'd2);
        for (int k = 0; k < 3; k++)
            applyStimulus(2'b01, 2'b00, 1'b0, 1'b0, 1'b0, "p0 miss");
        applyStimulus(2'b01, 2'b00, 1'b0, 1'b0, 1'b0, "p0 empty");
        checkExpect("p0 empty", 16'h0002, 8'h30, 4'b0000, 4'd2);
        for (int k = 0; k < 2; k++)
            applyStimulus(2'b10, 2'b00, 1'b0, 1'b0, 1'b0, "p1 miss");
        checkExpect("fifth shot", 16'h0002, 8'h10, 4'b0000, 4'd2);
        applyStimulus(2'b10, 2'b00, 1'b0, 1'b0, 1'b0, "p1 last");
        checkExpect("ammo escape", 16'h0002, 8'h00, 4'b0010, 4'd2);
        frames(RES, 1'b0);

        frames(FLY - 1, 1'b0);
        checkExpect("fly 299", 16'h0002, 8'h33, 4'b0000, 4'd3);
        applyStimulus('0, '0, 1'b1, 1'b0, 1'b0, "fly 300");
        checkExpect("time escape", 16'h0002, 8'h33, 4'b0010, 4'd3);
        applyStimulus('0, '0, 1'b0, 1'b0, 1'b0, "esc idle");
        frames(RES - 1, 1'b0);
        checkExpect("esc 59", 16'h0002, 8'h33, 4'b0010, 4'd3);
        applyStimulus('0, '0, 1'b1, 1'b0, 1'b0, "esc 60");
        checkExpect("release after esc", 16'h0002, 8'h33, 4'b1000, 4'd4);
        applyStimulus('0, '0, 1'b0, 1'b0, 1'b0, "to fly");

        frames(100, 1'b0);
        applyStimulus(2'b01, 2'b01, 1'b1, 1'b1, 1'b1, "paused shot");
        checkExpect("paused shot", 16'h0002, 8'h33, 4'b0000, 4'd4);
        frames(500, 1'b1);
        frames(FLY - 101, 1'b0);
        checkExpect("resume 299", 16'h0002, 8'h33, 4'b0000, 4'd4);
        applyStimulus('0, '0, 1'b1, 1'b0, 1'b0, "resume 300");
        checkExpect("resume escape", 16'h0002, 8'h33, 4'b0010, 4'd4);
        frames(RES - 1, 1'b0);
        applyStimulus('0, '0, 1'b1, 1'b0, 1'b0, "esc done");
        checkExpect("release pulse", 16'h0002, 8'h33, 4'b1000, 4'd5);
        applyStimulus('0, '0, 1'b0, 1'b0, 1'b1, "pause release");
        checkExpect("pause release", 16'h0002, 8'h33, 4'b0000, 4'd5);

        for (int k = 0; k < 4; k++)
            hitDuck(0);
        escapeDuck();
        waitFly();
        checkExpect("round pass", 16'h0006, 8'h33, 4'b0000, 4'd0);
        checkValue("round pass round", 64'(round_bcd), 64'h02);

        for (int k = 0; k < 5; k++)
            hitDuck(1);
        for (int k = 0; k < 5; k++)
            escapeDuck();
        checkExpect("round fail", 16'h0506, 8'h00, 4'b0001, 4'd10);
        checkValue("round fail round", 64'(round_bcd), 64'h02);
        for (int k = 0; k < 3; k++)
            applyStimulus('1, '1, 1'b1, 1'b0, 1'b0, "game over hold");
        checkExpect("game over hold", 16'h0506, 8'h00, 4'b0001, 4'd10);
        applyStimulus('0, '0, 1'b0, 1'b1, 1'b0, "restart");
        checkExpect("restart", 16'h0000, 8'h33, 4'b1000, 4'd0);
        checkValue("restart round", 64'(round_bcd), 64'h01);

        for (int k = 0; k < 99; k++)
            hitDuck(0);
        checkValue("score 99", 64'(score_bcd), 64'h0099);
        waitFly();
        applyStimulus(2'b01, 2'b01, 1'b0, 1'b0, 1'b0, "score sat");
        checkExpect("score sat", 16'h0099, 8'h32, 4'b0100, 4'd9);
        checkValue("round 10", 64'(round_bcd), 64'h10);
        frames(RES, 1'b0);
        waitFly();

        applyStimulus(2'b10, 2'b00, 1'b0, 1'b0, 1'b0, "pre reset");
        rst = 1'b0;
        #1;
        modelReset();
        checkReset("async reset");
        @(negedge clk);
        checkReset("held reset");
        rst = 1'b1;
        for (int k = 0; k < 2; k++)
            applyStimulus('0, '0, 1'b1, 1'b0, 1'b0, "after reset");
        checkReset("after reset");

        for (int k = 0; k < 4000; k++) begin
            logic [N-1:0] rs, rh;
            for (int i = 0; i < N; i++) begin
                rs[i] = ($urandom_range(3) == 0);
                rh[i] = ($urandom_range(1) == 0);
            end
            applyStimulus(rs, rh, 1'($urandom_range(1)), ($urandom_range(15) == 0),
                          ($urandom_range(7) == 0), "random");
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
